// File: rtl/bit_packer.sv
// bit_packer: serial bit stream to WIDTH-bit word packer; BIT_PACKER_MSB_FIRST_EN selects MSB-first packing
module bit_packer #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       bit_in,
    input  logic                       bit_valid,
    output logic                       bit_ready,
    input  logic                       flush,
    output logic [WIDTH-1:0]           word_out,
    output logic [$clog2(WIDTH+1)-1:0] word_bits,
    output logic                       word_valid,
    input  logic                       word_ready
);
    localparam int CW = $clog2(WIDTH+1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] buffer, buffer_nxt, word_out_nxt, onehot, fill_buf;
    logic [CW-1:0]    count, count_nxt, word_bits_nxt, fill_cnt;
    logic             word_valid_nxt, bit_ready_nxt, accept, done;

`ifdef BIT_PACKER_MSB_FIRST_EN
    assign onehot = {1'b1, {(WIDTH-1){1'b0}}} >> count;
`else
    assign onehot = {{(WIDTH-1){1'b0}}, 1'b1} << count;
`endif

    assign accept   = bit_valid && bit_ready;
    assign fill_buf = buffer | ((accept && bit_in) ? onehot : '0);
    assign fill_cnt = count + CW'(accept);
    assign done     = (state == FILL) && ((accept && fill_cnt == CW'(WIDTH)) || (flush && fill_cnt != '0));

    // next state: collect bits in FILL, present the word in HOLD until the consumer takes it
    always_comb begin
        state_nxt      = state;
        buffer_nxt     = buffer;
        count_nxt      = count;
        word_out_nxt   = word_out;
        word_bits_nxt  = word_bits;
        word_valid_nxt = word_valid;
        bit_ready_nxt  = bit_ready;
        if (state == FILL) begin
            buffer_nxt     = fill_buf;
            count_nxt      = fill_cnt;
            state_nxt      = done ? HOLD : FILL;
            word_out_nxt   = done ? fill_buf : word_out;
            word_bits_nxt  = done ? fill_cnt : word_bits;
            word_valid_nxt = done;
            bit_ready_nxt  = !done;
        end else if (word_ready) begin
            state_nxt      = FILL;
            buffer_nxt     = '0;
            count_nxt      = '0;
            word_out_nxt   = '0;
            word_bits_nxt  = '0;
            word_valid_nxt = 1'b0;
            bit_ready_nxt  = 1'b1;
        end
    end

    // state and output registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FILL;
            buffer     <= '0;
            count      <= '0;
            word_out   <= '0;
            word_bits  <= '0;
            word_valid <= 1'b0;
            bit_ready  <= 1'b0;
        end else begin
            state      <= state_nxt;
            buffer     <= buffer_nxt;
            count      <= count_nxt;
            word_out   <= word_out_nxt;
            word_bits  <= word_bits_nxt;
            word_valid <= word_valid_nxt;
            bit_ready  <= bit_ready_nxt;
        end
    end
endmodule
